// File: rtl/feature_frame_ctrl_if.sv
// Bundle between the feature-frame sequencer, the I2C read engine and the classifier.
// slave: the sequencer side. master: the engine/classifier/host side.
interface feature_frame_ctrl_if #(
  parameter int unsigned NUM_FEAT = 26
);
  logic                     start;
  logic                     rd_req;
  logic [7:0]               rd_addr;
  logic                     rd_ack;
  logic                     rd_err;
  logic [7:0]               rd_data;
  logic signed [7:0]        input_vector [NUM_FEAT];
  logic                     vec_valid;
  logic                     vec_ready;
  logic                     busy;
  logic                     err;

  modport slave (
    input  start, rd_ack, rd_err, rd_data, vec_ready,
    output rd_req, rd_addr, input_vector, vec_valid, busy, err
  );

  modport master (
    output start, rd_ack, rd_err, rd_data, vec_ready,
    input  rd_req, rd_addr, input_vector, vec_valid, busy, err
  );
endinterface

// File: rtl/feature_frame_ctrl.sv
// Feature-frame acquisition sequencer: one register read per feature with retry on
// timeout/NACK, atomic commit of the frame, valid/ready presentation to the classifier.
// Optional macro FEATURE_AUTO_RESTART_EN: after the handshake, restart acquisition
// immediately instead of returning to idle.
module feature_frame_ctrl #(
  parameter int unsigned NUM_FEAT    = 26,
  parameter logic [7:0]  BASE_ADDR   = 8'h00,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned RETRY_MAX   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  feature_frame_ctrl_if.slave  bus
);
  localparam int unsigned IdxW   = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam int unsigned TcntW  = $clog2(TIMEOUT_CYC);
  localparam int unsigned RetryW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

  localparam logic [IdxW-1:0]   IdxLast   = IdxW'(NUM_FEAT - 1);
  localparam logic [TcntW-1:0]  TcntLast  = TcntW'(TIMEOUT_CYC - 1);
  localparam logic [RetryW-1:0] RetryLast = RetryW'(RETRY_MAX);

  typedef enum logic [2:0] {
    StIdle, StReq, StWait, StRetry, StStore, StCommit, StPresent, StErr
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [TcntW-1:0]  tcnt_q, tcnt_d;
  logic              err_q, err_d;
  logic              req;
  logic              store_en;
  logic              commit_en;

  // Working buffer is filled per feature; the output vector only changes on commit.
  logic signed [7:0] fbuf_q [NUM_FEAT];
  logic signed [7:0] vec_q  [NUM_FEAT];

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      retry_q <= '0;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
    end
  end

  // Working buffer capture and atomic frame commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_FEAT; i++) begin
        fbuf_q[i] <= '0;
        vec_q[i]  <= '0;
      end
    end else begin
      if (store_en) begin
        fbuf_q[idx_q] <= bus.rd_data;
      end
      if (commit_en) begin
        vec_q <= fbuf_q;
      end
    end
  end

  // Next-state logic and read-request strobes.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    tcnt_d    = tcnt_q;
    err_d     = err_q;
    req       = 1'b0;
    store_en  = 1'b0;
    commit_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StReq;
          idx_d   = '0;
          retry_d = '0;
          tcnt_d  = '0;
          err_d   = 1'b0;
        end
      end
      StReq: begin
        req     = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        req = 1'b1;
        if (bus.rd_ack && !bus.rd_err) begin
          store_en = 1'b1;
          state_d  = StStore;
        end else if (bus.rd_ack || (tcnt_q == TcntLast)) begin
          state_d = StRetry;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      StRetry: begin
        tcnt_d = '0;
        if (retry_q < RetryLast) begin
          retry_d = retry_q + 1'b1;
          state_d = StReq;
        end else begin
          err_d   = 1'b1;
          state_d = StErr;
        end
      end
      StStore: begin
        retry_d = '0;
        tcnt_d  = '0;
        if (idx_q == IdxLast) begin
          state_d = StCommit;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StReq;
        end
      end
      StCommit: begin
        commit_en = 1'b1;
        state_d   = StPresent;
      end
      StPresent: begin
        if (bus.vec_ready) begin
`ifdef FEATURE_AUTO_RESTART_EN
          state_d = StReq;
          idx_d   = '0;
          retry_d = '0;
          tcnt_d  = '0;
`else
          state_d = StIdle;
`endif
        end
      end
      StErr: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Address is forced to zero outside a request so every output is 0 after reset.
  assign bus.rd_req       = req;
  assign bus.rd_addr      = req ? (BASE_ADDR + 8'(idx_q)) : 8'h00;
  assign bus.input_vector = vec_q;
  assign bus.vec_valid    = (state_q == StPresent);
  assign bus.busy         = (state_q != StIdle);
  assign bus.err          = err_q;

endmodule

// File: tb/tb_feature_frame_ctrl.sv
// Self-checking bench for feature_frame_ctrl with a behavioural I2C engine model.
module tb_feature_frame_ctrl;
  localparam int unsigned NF   = 26;
  localparam logic [7:0]  BASE = 8'h00;
  localparam int unsigned TO   = 16;
  localparam int unsigned RMAX = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  feature_frame_ctrl_if #(.NUM_FEAT(NF)) bus ();

  feature_frame_ctrl #(
    .NUM_FEAT   (NF),
    .BASE_ADDR  (BASE),
    .TIMEOUT_CYC(TO),
    .RETRY_MAX  (RMAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Engine model state.
  logic [7:0]        eng_data [256];
  logic [7:0]        addr_q [$];
  int                len_q [$];
  int                req_cnt = 0;
  int                ack_dly = 4;
  int                err_addr = -1;
  int                noack_addr = -1;
  bit                err_pending = 1'b0;
  bit                eng_en = 1'b1;
  bit                spur_ack = 1'b0;
  logic signed [7:0] exp_vec [NF];
  logic [7:0]        exp_addr [$];

  always @(posedge clk) cyc <= cyc + 1;

  // I2C engine: acks ack_dly+1 cycles into the wait, data from eng_data[addr].
  initial begin
    bus.rd_ack  = 1'b0;
    bus.rd_err  = 1'b0;
    bus.rd_data = 8'h00;
    forever begin
      @(negedge clk);
      bus.rd_ack = 1'b0;
      bus.rd_err = 1'b0;
      if (!eng_en) begin
        bus.rd_ack  = spur_ack;
        bus.rd_data = 8'($urandom);
        req_cnt     = 0;
      end else if (bus.rd_req) begin
        req_cnt++;
        if (req_cnt == 1) addr_q.push_back(bus.rd_addr);
        if (req_cnt == ack_dly + 2 && int'(bus.rd_addr) != noack_addr) begin
          bus.rd_ack = 1'b1;
          if (int'(bus.rd_addr) == err_addr && err_pending) begin
            bus.rd_err  = 1'b1;
            bus.rd_data = 8'($urandom);
            err_pending = 1'b0;
          end else begin
            bus.rd_data = eng_data[bus.rd_addr];
          end
        end
      end else begin
        if (req_cnt != 0) len_q.push_back(req_cnt);
        req_cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time expired, required completion");
    $fatal(1, "watchdog");
  end

  task automatic run_frame(input int tack, output int lat, output bit ok);
    int s;
    addr_q.delete();
    len_q.delete();
    ack_dly = tack;
    @(negedge clk);
    bus.start = 1'b1;
    s = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    ok  = 1'b0;
    lat = 0;
    for (int i = 0; i < 3000; i++) begin
      if (bus.vec_valid === 1'b1) begin
        ok  = 1'b1;
        lat = cyc - s;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_handshake(input bit with_start);
    @(negedge clk);
    bus.vec_ready = 1'b1;
    bus.start     = with_start;
    @(negedge clk);
    bus.vec_ready = 1'b0;
    bus.start     = 1'b0;
    checks++;
    if (bus.vec_valid !== 1'b0) begin
      errors++;
      $display("FAIL hs_valid_drop: vec_valid=%b required 0", bus.vec_valid);
    end
    for (int k = 0; k < NF; k++) begin
      checks++;
      if (bus.input_vector[k] !== exp_vec[k]) begin
        errors++;
        $display("FAIL hs_vec[%0d]: got %0d required %0d", k, bus.input_vector[k], exp_vec[k]);
      end
    end
`ifdef FEATURE_AUTO_RESTART_EN
    checks++;
    if (bus.rd_req !== 1'b1 || bus.rd_addr !== BASE) begin
      errors++;
      $display("FAIL auto_restart: rd_req=%b rd_addr=%h required 1/%h",
               bus.rd_req, bus.rd_addr, BASE);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < NF; k++) exp_vec[k] = '0;
`else
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.busy !== 1'b0 || bus.rd_req !== 1'b0) begin
        errors++;
        $display("FAIL stay_idle: busy=%b rd_req=%b required 0/0", bus.busy, bus.rd_req);
      end
      @(negedge clk);
    end
`endif
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus.rd_req, bus.busy, bus.vec_valid, bus.err} !== 4'b0 || bus.rd_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset_outs: req/busy/valid/err=%b%b%b%b addr=%h required 0000/00",
               bus.rd_req, bus.busy, bus.vec_valid, bus.err, bus.rd_addr);
    end
    for (int k = 0; k < NF; k++) begin
      exp_vec[k] = '0;
      checks++;
      if (bus.input_vector[k] !== 8'sd0) begin
        errors++;
        $display("FAIL reset_vec[%0d]: got %0d required 0", k, bus.input_vector[k]);
      end
    end
  endtask

  // Fault-free frame; latency, address sequence and contents checked against the model.
  task automatic test_frame(input int tack, input bit spec_data);
    int lat;
    bit ok;
    bit bad;
    for (int a = 0; a < 256; a++) eng_data[a] = spec_data ? 8'(a - 13) : 8'($urandom);
    run_frame(tack, lat, ok);
    checks++;
    if (!ok || lat != NF * (3 + tack) + 2) begin
      errors++;
      $display("FAIL frame_latency: ok=%0d lat=%0d required %0d", ok, lat, NF * (3 + tack) + 2);
    end
    exp_addr.delete();
    for (int k = 0; k < NF; k++) exp_addr.push_back(8'(BASE + k));
    bad = (addr_q.size() != exp_addr.size());
    if (!bad) for (int k = 0; k < NF; k++) if (addr_q[k] !== exp_addr[k]) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL frame_addrs: got %0d reads required %0d in order", addr_q.size(), NF);
    end
    for (int k = 0; k < NF; k++) exp_vec[k] = $signed(eng_data[8'(BASE + k)]);
    for (int k = 0; k < NF; k++) begin
      checks++;
      if (bus.input_vector[k] !== exp_vec[k]) begin
        errors++;
        $display("FAIL frame_vec[%0d]: got %0d required %0d", k, bus.input_vector[k], exp_vec[k]);
      end
    end
    if (spec_data) begin
      checks++;
      if (bus.input_vector[0] !== -8'sd13 || bus.input_vector[NF-1] !== 8'sd12) begin
        errors++;
        $display("FAIL frame_ends: got %0d/%0d required -13/12",
                 bus.input_vector[0], bus.input_vector[NF-1]);
      end
    end
    checks++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL frame_flags: err=%b busy=%b required 0/1", bus.err, bus.busy);
    end
    do_handshake(1'b0);
  endtask

  task automatic test_reset_mid;
    int lat;
    bit ok;
    bit hit;
    for (int a = 0; a < 256; a++) eng_data[a] = 8'($urandom_range(1, 255));
    ack_dly = 4;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (bus.rd_req === 1'b1 && bus.rd_addr === 8'h07) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL mid_reach_idx7: read of 0x07 not seen, required within budget");
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.rd_req, bus.busy, bus.vec_valid} !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset_outs: req/busy/valid=%b%b%b required 000",
               bus.rd_req, bus.busy, bus.vec_valid);
    end
    for (int k = 0; k < NF; k++) begin
      exp_vec[k] = '0;
      checks++;
      if (bus.input_vector[k] !== 8'sd0) begin
        errors++;
        $display("FAIL mid_reset_vec[%0d]: got %0d required 0", k, bus.input_vector[k]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    run_frame(2, lat, ok);
    checks++;
    if (!ok || addr_q.size() == 0 || addr_q[0] !== BASE) begin
      errors++;
      $display("FAIL mid_restart_addr: ok=%0d first=%h required %h", ok,
               (addr_q.size() != 0) ? addr_q[0] : 8'hxx, BASE);
    end
    for (int k = 0; k < NF; k++) exp_vec[k] = $signed(eng_data[8'(BASE + k)]);
    do_handshake(1'b0);
  endtask

  task automatic test_retry_err(input int tack);
    int lat;
    bit ok;
    bit bad;
    for (int a = 0; a < 256; a++) eng_data[a] = 8'($urandom);
    err_addr    = 5;
    err_pending = 1'b1;
    run_frame(tack, lat, ok);
    err_addr = -1;
    checks++;
    if (!ok || lat != NF * (3 + tack) + 2 + (tack + 3)) begin
      errors++;
      $display("FAIL retry_latency: ok=%0d lat=%0d required %0d", ok, lat,
               NF * (3 + tack) + 2 + (tack + 3));
    end
    exp_addr.delete();
    for (int k = 0; k < NF; k++) begin
      exp_addr.push_back(8'(BASE + k));
      if (k == 5) exp_addr.push_back(8'(BASE + k));
    end
    bad = (addr_q.size() != exp_addr.size());
    if (!bad) for (int k = 0; k < exp_addr.size(); k++) if (addr_q[k] !== exp_addr[k]) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL retry_addrs: got %0d reads required %0d with 0x05 reissued",
               addr_q.size(), exp_addr.size());
    end
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL retry_err_flag: err=%b required 0", bus.err);
    end
    for (int k = 0; k < NF; k++) exp_vec[k] = $signed(eng_data[8'(BASE + k)]);
    for (int k = 0; k < NF; k++) begin
      checks++;
      if (bus.input_vector[k] !== exp_vec[k]) begin
        errors++;
        $display("FAIL retry_vec[%0d]: got %0d required %0d", k, bus.input_vector[k], exp_vec[k]);
      end
    end
    do_handshake(1'b0);
  endtask

  task automatic test_timeout(input int tack);
    bit hit;
    bit bad;
    addr_q.delete();
    len_q.delete();
    ack_dly    = tack;
    noack_addr = 3;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (bus.err === 1'b1) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    noack_addr = -1;
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL timeout_err: err never rose, required 1");
    end
    bad = (addr_q.size() != 6) || (len_q.size() != 6);
    for (int k = 0; k < 6 && !bad; k++) begin
      if (addr_q[k] !== 8'(BASE + ((k < 3) ? k : 3))) bad = 1'b1;
      if (len_q[k] != ((k < 3) ? tack + 2 : TO + 1)) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL timeout_attempts: reads=%0d pulses=%0d required 6 (3 of %0d cycles at 0x03)",
               addr_q.size(), len_q.size(), TO + 1);
    end
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.busy !== 1'b0 || bus.err !== 1'b1 || bus.rd_req !== 1'b0) begin
        errors++;
        $display("FAIL timeout_idle: busy=%b err=%b rd_req=%b required 0/1/0",
                 bus.busy, bus.err, bus.rd_req);
      end
      @(negedge clk);
    end
    for (int k = 0; k < NF; k++) begin
      checks++;
      if (bus.input_vector[k] !== exp_vec[k]) begin
        errors++;
        $display("FAIL timeout_vec[%0d]: got %0d required %0d", k, bus.input_vector[k], exp_vec[k]);
      end
    end
  endtask

  task automatic test_present_hold;
    int lat;
    bit ok;
    for (int a = 0; a < 256; a++) eng_data[a] = 8'($urandom);
    run_frame(1, lat, ok);
    checks++;
    if (!ok || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL hold_frame: ok=%0d err=%b required 1/0 (start clears err)", ok, bus.err);
    end
    for (int k = 0; k < NF; k++) exp_vec[k] = $signed(eng_data[8'(BASE + k)]);
    eng_en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      bus.start = (i % 7 == 3);
      spur_ack  = (i % 5 == 2);
      @(negedge clk);
      checks++;
      if (bus.vec_valid !== 1'b1 || bus.rd_req !== 1'b0 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL hold_cycle%0d: valid=%b rd_req=%b busy=%b required 1/0/1",
                 i, bus.vec_valid, bus.rd_req, bus.busy);
      end
    end
    bus.start = 1'b0;
    spur_ack  = 1'b0;
    @(negedge clk);
    eng_en = 1'b1;
    for (int k = 0; k < NF; k++) begin
      checks++;
      if (bus.input_vector[k] !== exp_vec[k]) begin
        errors++;
        $display("FAIL hold_vec[%0d]: got %0d required %0d", k, bus.input_vector[k], exp_vec[k]);
      end
    end
    do_handshake(1'b1);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.vec_ready = 1'b0;
    test_reset();
    test_frame(4, 1'b1);
    test_frame($urandom_range(0, 6), 1'b0);
    test_frame($urandom_range(0, 6), 1'b0);
    test_reset_mid();
    test_retry_err($urandom_range(0, 5));
    test_timeout($urandom_range(0, 5));
    test_present_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
